// File: rtl/u8outwb.sv
// Output write-back stage: buffers u8mac result sets in a small FIFO and
// serializes the enabled lanes onto a byte-wide memory write port.
module u8outwb #(
   parameter int Np    = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   xrst,
   input  logic                   acvalid,
   input  logic [Np-1:0][7:0]     accd,
   input  logic [Np-1:0][28:0]    out_adr,
   input  logic [Np-1:0]          oen,
   output logic                   out_rdy,
   output logic                   wen,
   output logic [28:0]            wadr,
   output logic [7:0]             wdata,
   input  logic                   wrdy,
   input  logic                   clr,
   output logic                   busy,
   output logic                   ovf,
   output logic [31:0]            wcount,
   output logic                   wb_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(Np);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

   // Write port: a byte transfers on any rising edge where wen & wrdy; while
   // wen=1 and wrdy=0, wen/wadr/wdata stay frozen until the transfer happens.
   state_t                  state_q, state_d;
   logic [Np-1:0][7:0]      data_q [DEPTH];
   logic [Np-1:0][28:0]     adr_q  [DEPTH];
   logic [Np-1:0]           mask_q [DEPTH];
   logic [AW-1:0]           head_q, tail_q, head1;
   logic [AW:0]             count_q;
   logic [LW-1:0]           lane_q;

   logic                    fire, push, pop, load;
   logic [Np-1:0]           hm_after;
   logic                    cand_ok, sel_any;
   logic [Np-1:0]           cand_mask;
   logic [Np-1:0][7:0]      cand_data;
   logic [Np-1:0][28:0]     cand_adr;
   logic [LW-1:0]           sel_lane;

   assign fire     = (state_q == S_ISSUE) & wrdy;
   assign push     = acvalid & ~clr & (count_q < FULL);
   assign head1    = head_q + AW'(1);
   assign hm_after = mask_q[head_q] & ~(fire ? (Np'(1) << lane_q) : '0);
   assign pop      = (count_q != '0) & (hm_after == '0);

   // Choose the entry that will be head after this edge; when the FIFO is
   // about to be empty the incoming set is used directly to save a cycle.
   always_comb begin
      cand_ok   = 1'b0;
      cand_mask = oen;
      cand_data = accd;
      cand_adr  = out_adr;
      if (count_q == '0) begin
         cand_ok = push;
      end else if (!pop) begin
         cand_ok   = 1'b1;
         cand_mask = hm_after;
         cand_data = data_q[head_q];
         cand_adr  = adr_q[head_q];
      end else if (count_q > (AW+1)'(1)) begin
         cand_ok   = 1'b1;
         cand_mask = mask_q[head1];
         cand_data = data_q[head1];
         cand_adr  = adr_q[head1];
      end else begin
         cand_ok = push;
      end
   end

   always_comb begin
      sel_any  = 1'b0;
      sel_lane = '0;
      for (int i = Np - 1; i >= 0; i--) begin
         if (cand_mask[i]) begin
            sel_any  = 1'b1;
            sel_lane = LW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_IDLE;
      load    = 1'b0;
      if (clr) begin
         state_d = S_IDLE;
      end else if (state_q == S_ISSUE && !wrdy) begin
         state_d = S_ISSUE;
      end else if (cand_ok && sel_any) begin
         state_d = S_ISSUE;
         load    = 1'b1;
      end
   end

   always_comb begin
      wen      = (state_q == S_ISSUE);
      out_rdy  = (count_q < FULL);
      busy     = (count_q != '0) | (state_q == S_ISSUE);
      wb_state = state_q;
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         lane_q  <= '0;
         wadr    <= '0;
         wdata   <= '0;
         ovf     <= 1'b0;
         wcount  <= '0;
         for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
      end else if (clr) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf     <= 1'b0;
         wcount  <= '0;
      end else begin
         if (fire) begin
            wcount         <= wcount + 32'd1;
            mask_q[head_q] <= hm_after;
         end
         // A set arriving while full is lost even if a pop frees a slot now.
         if (acvalid && count_q == FULL) ovf <= 1'b1;
         if (push) begin
            mask_q[tail_q] <= oen;
            tail_q         <= tail_q + AW'(1);
         end
         if (pop) head_q <= head1;
         count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (load) begin
            lane_q <= sel_lane;
            wadr   <= cand_adr[sel_lane];
            wdata  <= cand_data[sel_lane];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[tail_q] <= accd;
         adr_q[tail_q]  <= out_adr;
      end
   end

endmodule

// File: tb/tb_u8outwb.sv
// Directed bench for u8outwb: write ordering, backpressure, overflow,
// empty-mask sets, clr and asynchronous reset.
module tb_u8outwb;

   localparam int Np = 32;

   logic                 clk = 1'b0;
   logic                 xrst;
   logic                 acvalid;
   logic [Np-1:0][7:0]   accd;
   logic [Np-1:0][28:0]  out_adr;
   logic [Np-1:0]        oen;
   logic                 out_rdy;
   logic                 wen;
   logic [28:0]          wadr;
   logic [7:0]           wdata;
   logic                 wrdy;
   logic                 clr;
   logic                 busy;
   logic                 ovf;
   logic [31:0]          wcount;
   logic                 wb_state;

   int total = 0;
   int bad   = 0;
   int nwr   = 0;
   logic [36:0] exp_q[$];

   u8outwb #(.Np(Np), .DEPTH(4)) dut (
      .clk(clk), .xrst(xrst), .acvalid(acvalid), .accd(accd),
      .out_adr(out_adr), .oen(oen), .out_rdy(out_rdy), .wen(wen),
      .wadr(wadr), .wdata(wdata), .wrdy(wrdy), .clr(clr), .busy(busy),
      .ovf(ovf), .wcount(wcount), .wb_state(wb_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_set(input logic [Np-1:0] en, input logic [7:0] dbase,
                           input logic [28:0] abase, input bit exp_it);
      for (int i = 0; i < Np; i++) begin
         accd[i]    = dbase + 8'(i);
         out_adr[i] = abase + 29'(i);
         if (en[i] && exp_it) exp_q.push_back({out_adr[i], accd[i]});
      end
      oen     = en;
      acvalid = 1'b1;
      tick();
      acvalid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", {63'd0, (exp_q.size() == 0 && busy == 1'b0)}, 64'd1);
   endtask

   // scoreboard: every accepted write must match the expected queue head,
   // and a stalled write must stay frozen
   logic        pend_q = 1'b0;
   logic [28:0] pend_adr;
   logic [7:0]  pend_data;

   always @(negedge clk) begin
      if (xrst && pend_q) begin
         chk("hold_wen", {63'd0, wen}, 64'd1);
         chk("hold_adr", {35'd0, wadr}, {35'd0, pend_adr});
         chk("hold_data", {56'd0, wdata}, {56'd0, pend_data});
      end
      if (xrst && wen && wrdy) begin
         nwr++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {27'd0, wadr, wdata}, 64'd0);
         end else begin
            chk("write", {27'd0, wadr, wdata}, {27'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
      pend_q    = xrst && wen && !wrdy && !clr;
      pend_adr  = wadr;
      pend_data = wdata;
   end

   initial begin
      logic [28:0] ea [3];
      logic [7:0]  ed [3];
      int          n0;
      ea = '{29'h1000, 29'h1005, 29'h101F};
      ed = '{8'd1, 8'd6, 8'd32};

      xrst = 1'b0; acvalid = 1'b0; accd = '0; out_adr = '0; oen = '0;
      wrdy = 1'b0; clr = 1'b0;
      tick();
      tick();
      chk("rst_out_rdy", {63'd0, out_rdy}, 64'd1);
      chk("rst_wen", {63'd0, wen}, 64'd0);
      chk("rst_wadr", {35'd0, wadr}, 64'd0);
      chk("rst_wdata", {56'd0, wdata}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_wcount", {32'd0, wcount}, 64'd0);
      xrst = 1'b1;
      tick();

      // single set, lanes 0/5/31, back-to-back writes
      wrdy = 1'b1;
      send_set(32'h8000_0021, 8'd1, 29'h1000, 1'b1);
      for (int w = 0; w < 3; w++) begin
         chk("t1_wen", {63'd0, wen}, 64'd1);
         chk("t1_wadr", {35'd0, wadr}, {35'd0, ea[w]});
         chk("t1_wdata", {56'd0, wdata}, {56'd0, ed[w]});
         tick();
      end
      chk("t1_wen_off", {63'd0, wen}, 64'd0);
      chk("t1_busy", {63'd0, busy}, 64'd0);
      chk("t1_wcount", {32'd0, wcount}, 64'd3);

      // same set with wrdy 0,0,1 per write
      wrdy = 1'b0;
      send_set(32'h8000_0021, 8'd1, 29'h1000, 1'b1);
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 2; k++) begin
            chk("t2_wen", {63'd0, wen}, 64'd1);
            chk("t2_wadr", {35'd0, wadr}, {35'd0, ea[w]});
            chk("t2_wdata", {56'd0, wdata}, {56'd0, ed[w]});
            tick();
         end
         wrdy = 1'b1;
         tick();
         wrdy = 1'b0;
      end
      chk("t2_wen_off", {63'd0, wen}, 64'd0);
      chk("t2_busy", {63'd0, busy}, 64'd0);
      chk("t2_wcount", {32'd0, wcount}, 64'd6);

      // empty-mask set followed by a lane-2-only set
      wrdy = 1'b1;
      send_set('0, 8'h40, 29'h2000, 1'b1);
      chk("t4_no_write", {63'd0, wen}, 64'd0);
      send_set(32'h0000_0004, 8'h40, 29'h2000, 1'b1);
      n0 = 0;
      while (!wen && n0 < 1) begin
         tick();
         n0++;
      end
      chk("t4_wen", {63'd0, wen}, 64'd1);
      chk("t4_wadr", {35'd0, wadr}, 64'h2002);
      chk("t4_wdata", {56'd0, wdata}, 64'h42);
      wait_drain(10);
      chk("t4_wcount", {32'd0, wcount}, 64'd7);

      // overflow: five full sets with the port stalled
      wrdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t3_rdy_before", {63'd0, out_rdy}, {63'd0, (k < 4)});
         send_set('1, 8'(k * 32), 29'h4000 + 29'(k * 256), (k < 4));
      end
      chk("t3_out_rdy", {63'd0, out_rdy}, 64'd0);
      chk("t3_ovf", {63'd0, ovf}, 64'd1);
      chk("t3_busy", {63'd0, busy}, 64'd1);
      n0 = nwr;
      wrdy = 1'b1;
      wait_drain(300);
      chk("t3_nwrites", 64'(nwr - n0), 64'd128);
      chk("t3_rdy_after", {63'd0, out_rdy}, 64'd1);
      chk("t3_wcount", {32'd0, wcount}, 64'd135);
      chk("t3_ovf_sticky", {63'd0, ovf}, 64'd1);

      // clr with two sets queued, ovf set, and a push in the same cycle
      wrdy = 1'b0;
      send_set('1, 8'h11, 29'h3000, 1'b0);
      send_set('1, 8'h22, 29'h3100, 1'b0);
      chk("t6_busy_pre", {63'd0, busy}, 64'd1);
      oen = '1;
      acvalid = 1'b1;
      clr = 1'b1;
      tick();
      acvalid = 1'b0;
      clr = 1'b0;
      chk("t6_wen", {63'd0, wen}, 64'd0);
      chk("t6_busy", {63'd0, busy}, 64'd0);
      chk("t6_ovf", {63'd0, ovf}, 64'd0);
      chk("t6_wcount", {32'd0, wcount}, 64'd0);
      chk("t6_out_rdy", {63'd0, out_rdy}, 64'd1);
      tick();
      chk("t6_still_idle", {62'd0, wen, busy}, 64'd0);

      // async reset while a write is being accepted
      wrdy = 1'b1;
      send_set(32'h0000_0018, 8'h50, 29'h5000, 1'b1);
      chk("t5_wadr0", {35'd0, wadr}, 64'h5003);
      tick();
      chk("t5_wadr1", {35'd0, wadr}, 64'h5004);
      chk("t5_wcount_pre", {32'd0, wcount}, 64'd1);
      #2;
      xrst = 1'b0;
      #1;
      chk("t5_wen", {63'd0, wen}, 64'd0);
      chk("t5_wadr", {35'd0, wadr}, 64'd0);
      chk("t5_wdata", {56'd0, wdata}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_out_rdy", {63'd0, out_rdy}, 64'd1);
      chk("t5_wcount", {32'd0, wcount}, 64'd0);
      exp_q.delete();
      tick();
      chk("t5_wen_held", {63'd0, wen}, 64'd0);
      xrst = 1'b1;
      tick();
      send_set(32'h0000_0080, 8'h90, 29'h6000, 1'b1);
      chk("t5_new_wadr", {35'd0, wadr}, 64'h6007);
      chk("t5_new_wdata", {56'd0, wdata}, 64'h97);
      wait_drain(10);
      chk("t5_new_wcount", {32'd0, wcount}, 64'd1);

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
